// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the program-counter / fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Provides the fetch FSM state encoding (2-bit), the default datapath width
// and the default reset PC used by pc_fetch_unit.
package pc_fetch_unit_pkg;

  localparam int         DEF_WIDTH    = 8;
  localparam logic [7:0] DEF_RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer for the 8-bit multicycle core.
// Latency: instruction valid 1 cycle after FETCH entry with a zero-wait memory; 1 instr / 2 cycles.
// Backpressure: holds mem_req until mem_ready; holds ir_out/ir_valid until ir_ack.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   halt                blocks leaving IDLE and the HOLD->FETCH shortcut
//   pc_out, pc_inc_in   PC to the external incrementer and its (pc+1) result back
//   mem_req/addr/ready/rdata   instruction memory request handshake
//   ir_out, ir_valid, ir_ack   instruction register presented to decode
//   branch_en, branch_target   PC redirect, honoured only together with ir_ack in HOLD
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             halt,
  output logic [WIDTH-1:0] pc_out,
  input  logic [WIDTH-1:0] pc_inc_in,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] ir_out,
  output logic             ir_valid,
  input  logic             ir_ack,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (!halt) state_d = S_FETCH;
      end

      // FETCH and WAIT share the capture path; the only difference is that a
      // miss in FETCH moves to WAIT while a miss in WAIT simply stays.
      S_FETCH, S_WAIT: begin
        if (mem_ready) begin
          ir_d       = mem_rdata;
          pc_d       = pc_inc_in;   // the single PC advance per captured instruction
          ir_valid_d = 1'b1;
          state_d    = S_HOLD;
        end else begin
          state_d    = S_WAIT;
        end
      end

      S_HOLD: begin
        if (ir_ack) begin
          ir_valid_d = 1'b0;
          if (branch_en) pc_d = branch_target;
          state_d = halt ? S_IDLE : S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Decoded straight from the state register so an asynchronous reset
  // mid-request drops mem_req immediately.
  assign mem_req  = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign pc_out   = pc_q;
  assign mem_addr = pc_q;
  assign ir_out   = ir_q;
  assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       halt;
  logic [7:0] pc_out;
  logic [7:0] pc_inc_in;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic [7:0] ir_out;
  logic       ir_valid;
  logic       ir_ack;
  logic       branch_en;
  logic [7:0] branch_target;

  int n_assert = 0;
  int n_fail   = 0;
  int req_cycles;

  // External incrementer, (pc + 1) mod 256.
  assign pc_inc_in = pc_out + 8'd1;

  always #5 clock = ~clock;

  pc_fetch_unit #(.WIDTH(8), .RESET_PC(8'h00)) dut (
    .clock         (clock),
    .reset         (reset),
    .halt          (halt),
    .pc_out        (pc_out),
    .pc_inc_in     (pc_inc_in),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .ir_out        (ir_out),
    .ir_valid      (ir_valid),
    .ir_ack        (ir_ack),
    .branch_en     (branch_en),
    .branch_target (branch_target)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; halt = 1'b1; mem_ready = 1'b0; mem_rdata = 8'h00;
    ir_ack = 1'b0; branch_en = 1'b0; branch_target = 8'h00;

    // Reset state
    #3;
    chk("rst_pc",       pc_out,   8'h00);
    chk("rst_ir",       ir_out,   8'h00);
    chk("rst_ir_valid", {7'd0, ir_valid}, 8'h00);
    chk("rst_mem_req",  {7'd0, mem_req},  8'h00);
    chk("rst_mem_addr", mem_addr, 8'h00);

    // 1: zero-wait fetch after reset release
    @(negedge clock);
    reset = 1'b1; halt = 1'b0; mem_ready = 1'b1; mem_rdata = 8'hA5;
    step();  // IDLE -> FETCH
    chk("t1_fetch_req",   {7'd0, mem_req},  8'h01);
    chk("t1_fetch_addr",  mem_addr, 8'h00);
    chk("t1_fetch_valid", {7'd0, ir_valid}, 8'h00);
    step();  // FETCH -> HOLD
    chk("t1_valid",    {7'd0, ir_valid}, 8'h01);
    chk("t1_ir",       ir_out,   8'hA5);
    chk("t1_pc",       pc_out,   8'h01);
    chk("t1_hold_req", {7'd0, mem_req},  8'h00);

    // 2: memory ready delayed 3 cycles, ack with halt=0 goes straight to FETCH
    mem_ready = 1'b0; ir_ack = 1'b1; mem_rdata = 8'h3C;
    step();  // HOLD -> FETCH
    ir_ack = 1'b0;
    chk("t2_ack_clears_valid", {7'd0, ir_valid}, 8'h00);
    chk("t2_pc_not_on_ack",    pc_out, 8'h01);
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (!mem_req) break;
      req_cycles++;
      chk("t2_addr_stable", mem_addr, 8'h01);
      chk("t2_no_early_valid", {7'd0, ir_valid}, 8'h00);
      if (req_cycles == 4) mem_ready = 1'b1;
      step();
    end
    mem_ready = 1'b0;
    chk("t2_req_cycles", 8'(req_cycles), 8'd4);
    chk("t2_valid", {7'd0, ir_valid}, 8'h01);
    chk("t2_ir",    ir_out, 8'h3C);
    chk("t2_pc",    pc_out, 8'h02);

    // Redirect to 04 so the next capture leaves PC at 05
    ir_ack = 1'b1; branch_en = 1'b1; branch_target = 8'h04;
    mem_ready = 1'b1; mem_rdata = 8'h11;
    step();  // HOLD -> FETCH @04
    ir_ack = 1'b0; branch_en = 1'b0;
    chk("t4_pre_addr", mem_addr, 8'h04);
    step();  // FETCH -> HOLD
    chk("t4_pre_pc", pc_out, 8'h05);
    chk("t4_pre_ir", ir_out, 8'h11);

    // 4: branch on ack from HOLD at PC 05
    ir_ack = 1'b1; branch_en = 1'b1; branch_target = 8'h40; mem_rdata = 8'h77;
    step();  // HOLD -> FETCH @40
    ir_ack = 1'b0;
    chk("t4_addr", mem_addr, 8'h40);
    chk("t4_req",  {7'd0, mem_req}, 8'h01);
    step();  // FETCH -> HOLD
    chk("t4_pc", pc_out, 8'h41);
    chk("t4_ir", ir_out, 8'h77);

    // 5: no ack for 5 cycles (branch_en and mem_ready noise ignored), then halt+ack
    branch_target = 8'h99; mem_rdata = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_ir",    ir_out, 8'h77);
      chk("t5_pc",    pc_out, 8'h41);
      chk("t5_req",   {7'd0, mem_req},  8'h00);
      chk("t5_valid", {7'd0, ir_valid}, 8'h01);
    end
    branch_en = 1'b0; halt = 1'b1; ir_ack = 1'b1;
    step();  // HOLD -> IDLE
    ir_ack = 1'b0;
    chk("t5_idle_valid", {7'd0, ir_valid}, 8'h00);
    chk("t5_idle_req",   {7'd0, mem_req},  8'h00);
    step();
    step();
    chk("t5_parked_req", {7'd0, mem_req}, 8'h00);
    chk("t5_parked_ir",  ir_out, 8'h77);
    chk("t5_parked_pc",  pc_out, 8'h41);

    // 3: wrap FF -> 00
    halt = 1'b0; mem_rdata = 8'h22;
    step();  // IDLE -> FETCH @41
    chk("t3_pre_addr", mem_addr, 8'h41);
    step();  // -> HOLD, pc 42
    ir_ack = 1'b1; branch_en = 1'b1; branch_target = 8'hFF; mem_rdata = 8'hEE;
    step();  // -> FETCH @FF
    ir_ack = 1'b0; branch_en = 1'b0;
    chk("t3_addr_ff", mem_addr, 8'hFF);
    step();  // -> HOLD, pc wraps
    chk("t3_pc_wrap", pc_out, 8'h00);
    chk("t3_ir",      ir_out, 8'hEE);
    ir_ack = 1'b1; mem_ready = 1'b0;
    step();  // -> FETCH @00
    ir_ack = 1'b0;
    chk("t3_next_addr", mem_addr, 8'h00);

    // 6: reset mid-WAIT. Move PC to 30 first so the return to RESET_PC is visible.
    mem_ready = 1'b1; mem_rdata = 8'h10;
    step();  // FETCH -> HOLD, pc 01
    ir_ack = 1'b1; branch_en = 1'b1; branch_target = 8'h30; mem_ready = 1'b0;
    step();  // -> FETCH @30
    ir_ack = 1'b0; branch_en = 1'b0;
    step();  // -> WAIT
    chk("t6_wait_req",  {7'd0, mem_req}, 8'h01);
    chk("t6_wait_addr", mem_addr, 8'h30);
    mem_ready = 1'b1; mem_rdata = 8'h5A;
    #2 reset = 1'b0;
    #1;
    chk("t6_async_req",   {7'd0, mem_req},  8'h00);
    chk("t6_async_valid", {7'd0, ir_valid}, 8'h00);
    chk("t6_async_pc",    pc_out, 8'h00);
    step();
    chk("t6_rst_ir", ir_out, 8'h00);
    @(negedge clock);
    reset = 1'b1; halt = 1'b1;
    step();
    chk("t6_stale_valid", {7'd0, ir_valid}, 8'h00);
    chk("t6_stale_ir",    ir_out, 8'h00);
    chk("t6_stale_req",   {7'd0, mem_req}, 8'h00);
    halt = 1'b0; mem_ready = 1'b0;
    step();  // IDLE -> FETCH @RESET_PC
    chk("t6_first_addr", mem_addr, 8'h00);
    chk("t6_first_req",  {7'd0, mem_req}, 8'h01);
    mem_ready = 1'b1; mem_rdata = 8'hC3;
    step();  // -> HOLD
    chk("t6_ir", ir_out, 8'hC3);
    chk("t6_pc", pc_out, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
